muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_signfix.sv | 14 +
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_muldiv_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants, state encoding and decode helpers for muldiv_unit
package muldiv_pkg;

  localparam logic [2:0] ALUOP_RTYPE = 3'b010;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_DIV  = 2'd2;
  localparam state_t ST_FIX  = 2'd3;

  // Multi-cycle multiply/divide ops
  function automatic logic is_iterative(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
  endfunction

  // Any op that touches HI/LO and so must wait for an in-flight result
  function automatic logic is_hilo(input logic [5:0] fn);
    return is_iterative(fn) || (fn == FN_MFHI) || (fn == FN_MTHI) ||
           (fn == FN_MFLO) || (fn == FN_MTLO);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - conditional two's-complement negation (magnitude in, signed out and back)
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  // Negation of the most negative value wraps to itself, which is the
  // unsigned magnitude the iterative datapath expects.
  assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative HI/LO multiply/divide unit with fixed WIDTH+1 cycle latency
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       aluOp,
  input  logic [5:0]       functionCode,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] readData
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_hi;    // running upper product / partial remainder
  logic [WIDTH-1:0] acc_lo;    // multiplier bits / dividend shifting into quotient
  logic [WIDTH-1:0] opb_q;     // multiplicand or divisor magnitude
  logic             is_div_q;
  logic             neg_lo_q;  // negate product or quotient in FIX
  logic             neg_hi_q;  // negate remainder in FIX
  logic             dbz_q;

  logic             rtype, issue, op_iter, op_div, signed_op, b_zero;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0] quo_res, rem_res;

  assign busy      = (state != ST_IDLE);
  assign rtype     = (aluOp == ALUOP_RTYPE);
  assign issue     = start && rtype && !busy;
  assign op_iter   = issue && is_iterative(functionCode);
  assign op_div    = functionCode[1];
  assign signed_op = !functionCode[0];
  assign b_zero    = (operandB == '0);
  assign a_neg     = signed_op && operandA[WIDTH-1];
  assign b_neg     = signed_op && operandB[WIDTH-1];
  assign stall     = busy && start && rtype && is_hilo(functionCode);

  muldiv_signfix #(.W(WIDTH)) a_fix (.value(operandA), .negate(a_neg), .result(a_mag));
  muldiv_signfix #(.W(WIDTH)) b_fix (.value(operandB), .negate(b_neg), .result(b_mag));

  muldiv_signfix #(.W(2*WIDTH)) prod_fix (.value({acc_hi, acc_lo}), .negate(neg_lo_q), .result(prod_res));
  muldiv_signfix #(.W(WIDTH))   quo_fix  (.value(acc_lo), .negate(neg_lo_q), .result(quo_res));
  muldiv_signfix #(.W(WIDTH))   rem_fix  (.value(acc_hi), .negate(neg_hi_q), .result(rem_res));

  // One shift-add multiply step and one restoring divide step, evaluated every cycle
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + ({1'b0, opb_q} & {(WIDTH+1){acc_lo[0]}});
    div_trial = {acc_hi, acc_lo[WIDTH-1]};
    div_ok    = (div_trial >= {1'b0, opb_q});
    div_rem   = div_trial[WIDTH-1:0] - opb_q;
  end

  // Sequencer and iterative datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_iter) begin
            state    <= op_div ? ST_DIV : ST_MUL;
            count    <= CW'(WIDTH - 1);
            acc_hi   <= '0;
            // A zero divisor runs the raw dividend through unsigned steps,
            // which leaves quotient all ones and remainder = operandA.
            acc_lo   <= (op_div && b_zero) ? operandA : a_mag;
            opb_q    <= b_mag;
            is_div_q <= op_div;
            neg_lo_q <= (a_neg ^ b_neg) && !(op_div && b_zero);
            neg_hi_q <= op_div && a_neg && !b_zero;
            dbz_q    <= op_div && b_zero;
          end
        end
        ST_MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          if (count == '0) state <= ST_FIX;
          else             count <= count - CW'(1);
        end
        ST_DIV: begin
          acc_hi <= div_ok ? div_rem : div_trial[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
          if (count == '0) state <= ST_FIX;
          else             count <= count - CW'(1);
        end
        default: state <= ST_IDLE;  // ST_FIX
      endcase
    end
  end

  // Architectural HI/LO plus registered completion flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      divByZero <= 1'b0;
    end else begin
      done      <= (state == ST_FIX);
      divByZero <= (state == ST_FIX) && dbz_q;
      if (state == ST_FIX) begin
        if (is_div_q) begin
          hi <= rem_res;
          lo <= quo_res;
        end else begin
          {hi, lo} <= prod_res;
        end
      end else if (issue && functionCode == FN_MTHI) begin
        hi <= operandA;
      end else if (issue && functionCode == FN_MTLO) begin
        lo <= operandA;
      end
    end
  end

  // MFHI/MFLO read port
  always_comb begin
    readData = '0;
    if (functionCode == FN_MFHI)      readData = hi;
    else if (functionCode == FN_MFLO) readData = lo;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  aluOp;
  logic [5:0]  functionCode;
  logic [31:0] operandA, operandB;
  logic        busy, stall, done, divByZero;
  logic [31:0] hi, lo, readData;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  logic flag;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .aluOp(aluOp),
    .functionCode(functionCode), .operandA(operandA), .operandB(operandB),
    .busy(busy), .stall(stall), .done(done), .divByZero(divByZero),
    .hi(hi), .lo(lo), .readData(readData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue at posedge+1, accept on next edge (edge 0), then scramble operands and wait for done
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int latency);
    start = 1'b1; aluOp = ALUOP_RTYPE; functionCode = f; operandA = a; operandB = b;
    @(posedge clk); #1;
    start = 1'b0; operandA = 32'hA5A5_5A5A; operandB = 32'h0F0F_F0F0;
    latency = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin latency = k; break; end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; aluOp = 3'b000; functionCode = 6'b0;
    operandA = '0; operandB = '0;
    #1 reset = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", divByZero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_stall", stall, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(FN_MULT, 32'hFFFF_FFFF, 32'h0000_0002, lat);
    chk("mult_lat", lat, 33);
    chk("mult_busy", busy, 0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    chk("mult_done_1cyc", done, 0);

    run_op(FN_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, lat);
    chk("multu_lat", lat, 33);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    run_op(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk("multu_max_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo, 32'h0000_0001);

    run_op(FN_MULT, 32'h8000_0000, 32'h8000_0000, lat);
    chk("mult_min_hi", hi, 32'h4000_0000);
    chk("mult_min_lo", lo, 32'h0000_0000);

    run_op(FN_DIV, 32'hFFFF_FFF9, 32'h0000_0002, lat);
    chk("div_lat", lat, 33);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_dbz", divByZero, 0);

    run_op(FN_DIVU, 32'd7, 32'd2, lat);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    run_op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0000_0000);

    run_op(FN_DIVU, 32'd5, 32'd0, lat);
    chk("dz_lat", lat, 33);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_hi", hi, 32'd5);
    chk("dz_flag", divByZero, 1);
    @(posedge clk); #1;
    chk("dz_flag_1cyc", divByZero, 0);

    run_op(FN_DIV, 32'hFFFF_FFF9, 32'd0, lat);
    chk("dzs_lo", lo, 32'hFFFF_FFFF);
    chk("dzs_hi", hi, 32'hFFFF_FFF9);
    chk("dzs_flag", divByZero, 1);

    // Ignored issues: wrong aluOp, non-HI/LO funct
    start = 1'b1; aluOp = 3'b000; functionCode = FN_MULT; operandA = 32'd9; operandB = 32'd9;
    @(posedge clk); #1;
    chk("ign_aluop_busy", busy, 0);
    aluOp = ALUOP_RTYPE; functionCode = 6'b100000;
    @(posedge clk); #1;
    chk("ign_funct_busy", busy, 0);
    chk("ign_hi", hi, 32'hFFFF_FFF9);
    start = 1'b0;

    // MTLO / MTHI while idle
    start = 1'b1; functionCode = FN_MTLO; operandA = 32'h0000_1234;
    @(posedge clk); #1;
    chk("mtlo_lo", lo, 32'h0000_1234);
    chk("mtlo_busy", busy, 0);
    chk("mtlo_done", done, 0);
    chk("mtlo_hi_keep", hi, 32'hFFFF_FFF9);
    functionCode = FN_MTHI; operandA = 32'h0000_ABCD;
    @(posedge clk); #1;
    chk("mthi_hi", hi, 32'h0000_ABCD);
    start = 1'b0;
    @(posedge clk); #1;
    chk("mthi_no_done", done, 0);
    functionCode = FN_MFLO; #1;
    chk("mflo_read", readData, 32'h0000_1234);
    functionCode = FN_MFHI; #1;
    chk("mfhi_read", readData, 32'h0000_ABCD);
    functionCode = 6'b100001; #1;
    chk("other_read", readData, 0);

    // MULT then MFHI three cycles later: stall until done
    start = 1'b1; aluOp = ALUOP_RTYPE; functionCode = FN_MULT;
    operandA = 32'h0001_0000; operandB = 32'h0003_0000;
    @(posedge clk); #1;
    start = 1'b0; operandA = 32'h1111_1111; operandB = 32'h2222_2222;
    lat = -1; flag = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
      if (k >= 3 && stall !== 1'b1) flag = 1'b0;
      if (k == 10) chk("hold_hi", hi, 32'h0000_ABCD);
      if (k == 2) begin start = 1'b1; functionCode = FN_MFHI; end
    end
    chk("mfhi_stall_held", flag, 1);
    chk("mfhi_lat", lat, 33);
    chk("mfhi_stall_done", stall, 0);
    chk("mfhi_read_new", readData, 32'h0000_0003);
    chk("mfhi_lo", lo, 32'h0000_0000);
    start = 1'b0;
    @(posedge clk); #1;

    // Reset at edge 10 of a DIV
    start = 1'b1; aluOp = ALUOP_RTYPE; functionCode = FN_DIV;
    operandA = 32'd100; operandB = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hi", hi, 0);
    chk("mid_rst_lo", lo, 0);
    chk("mid_rst_done", done, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    flag = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) flag = 1'b0;
    end
    chk("mid_rst_quiet", flag, 1);

    run_op(FN_MULT, 32'd3, 32'd4, lat);
    chk("post_rst_lat", lat, 33);
    chk("post_rst_lo", lo, 32'd12);
    chk("post_rst_hi", hi, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
